vga_timing_out: RTL and testbench
=================================

// Module: vga_timing_out
// PURPOSE
//  640x480@60 VGA timing generator and output stage for the badGPU top level.
//  Drives pixel coordinates to the upstream renderer and accepts its colour RENDER_LAT cycles later.
//  Delays sync/blank to match, then drives the packed, registered word on uo_out (TinyVGA Pmod order).
//  Sits directly upstream of the top-level pins: tt_um_emern_top assigns uo_out = vga_out.
// PARAMETERS
//  H_ACTIVE    640  visible pixels per line
//  H_FP        16   horizontal front porch (clocks)
//  H_SYNC      96   hsync pulse width (clocks)
//  H_BP        48   horizontal back porch (clocks)
//  V_ACTIVE    480  visible lines per frame
//  V_FP        10   vertical front porch (lines)
//  V_SYNC      2    vsync pulse width (lines)
//  V_BP        33   vertical back porch (lines)
//  RENDER_LAT  2    renderer latency coord->colour, 0..7
// PORTS
//  clk          in   1   pixel clock, 25.175 MHz nominal
//  rst          in   1   asynchronous, active-high reset
//  ena          in   1   advance enable; 0 = freeze everything
//  pix_x        out  10  current horizontal count
//  pix_y        out  10  current vertical count
//  pix_valid    out  1   pix_x < H_ACTIVE && pix_y < V_ACTIVE
//  line_start   out  1   1 when pix_x==0 && ena
//  frame_start  out  1   1 when pix_x==0 && pix_y==0 && ena
//  rgb_in       in   6   {r[1:0],g[1:0],b[1:0]} for coords issued RENDER_LAT cycles earlier
//  vga_out      out  8   {hsync,b[0],g[0],r[0],vsync,b[1],g[1],r[1]}, registered
// BEHAVIOUR
//  - Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL=800); v_cnt 0..V_TOTAL-1 (V_TOTAL=525). Advance only when ena=1.
//  - Wrap: h==H_TOTAL-1 -> h=0 and v+1; additionally v==V_TOTAL-1 -> v=0.
//  - pix_x/pix_y/pix_valid/line_start/frame_start derive from counter registers only; they are not registered again.
//  - Raw hsync_a = (H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC), i.e. h 656..751.
//  - Raw vsync_a = (V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC), i.e. v 490..491.
//  - Raw blank = !pix_valid.
//  - Delay line: {hsync_a,vsync_a,blank}, RENDER_LAT stages, shift only when ena=1.
//  - Output register loads when ena=1:
//      hsync = ~hsync_d, vsync = ~vsync_d (syncs are active-low);
//      colour = blank_d ? 0 : rgb_in.
//  - Latency: coord issued at cycle t appears on vga_out at cycle t+RENDER_LAT+1.
//  - RENDER_LAT=0: rgb_in is sampled in the same cycle its coords are issued.
//  - Reset (async, any time incl. mid-frame):
//      h=v=0; delay stages clear to sync-inactive, blank=1;
//      vga_out = 8'b1000_1000 (syncs high, colour 0).
//    First cycle after release: pix_x=0, pix_y=0, frame_start=1 (if ena=1).
//  - ena=0: counters, delay line and vga_out hold; line_start/frame_start=0; rgb_in ignored.
//  - rgb_in is never observed while blank_d=1, so X on rgb_in during blanking must not reach vga_out.
// TESTING
//  1. Hold rst; release with ena=1 ->
//       vga_out==8'h88 during reset; cycle 0: pix_x=0, pix_y=0, frame_start=1.
//  2. RENDER_LAT=2, rgb_in=6'h3F constant ->
//       colour bits all 1 on cycles 3..642; 0 from cycle 643 to line end.
//  3. Line 0 ->
//       vga_out[7] low exactly cycles 659..754 (96 clocks); next line_start at cycle 800.
//  4. Run a full frame ->
//       vsync low for 1600 clocks starting 490*800+3;
//       frame_start again at cycle 420000 with pix_y=0.
//  5. Drop ena for 10 cycles at h=300 ->
//       pix_x stays 300, vga_out frozen; on re-enable resumes at 301 with no skipped count.
//  6. Assert rst at (h=700, v=491) for 2 cycles ->
//       vga_out=8'h88 immediately; after release counting restarts from (0,0) with frame_start.

Source files
------------

// File: rtl/vga_timing_out.sv
// 640x480@60 VGA timing generator with a renderer-latency-matched sync/blank delay line
// and a registered TinyVGA-ordered output word.
module vga_timing_out #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int RENDER_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       pix_valid,
    output logic       line_start,
    output logic       frame_start,
    input  logic [5:0] rgb_in,
    output logic [7:0] vga_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [7:0] VGA_IDLE = 8'b1000_1000;

    // Raw syncs here are active-high; inversion to pin polarity happens at the output register.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{hsync: 1'b0, vsync: 1'b0, blank: 1'b1};

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    ctl_t       ctl_raw;
    ctl_t       ctl_d;
    logic [5:0] colour;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would let h_cnt's update leak into v_cnt's decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (ena) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign pix_x       = h_cnt;
    assign pix_y       = v_cnt;
    assign pix_valid   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign line_start  = ena && (h_cnt == 10'd0);
    assign frame_start = ena && (h_cnt == 10'd0) && (v_cnt == 10'd0);

    assign ctl_raw.hsync = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign ctl_raw.vsync = (v_cnt >= VS_START) && (v_cnt < VS_END);
    assign ctl_raw.blank = !pix_valid;

    generate
        if (RENDER_LAT == 0) begin : g_no_delay
            assign ctl_d = ctl_raw;
        end else begin : g_delay
            ctl_t stage [RENDER_LAT];

            // NOTE: the delay stages are reset, unlike a plain data pipe, because their
            // contents reach the pins: they must come up blank with syncs inactive.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < RENDER_LAT; i++) begin
                        stage[i] <= CTL_IDLE;
                    end
                end else if (ena) begin
                    stage[0] <= ctl_raw;
                    for (int i = 1; i < RENDER_LAT; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign ctl_d = stage[RENDER_LAT-1];
        end
    endgenerate

    // NOTE: a select-driven mux (with its default assigned unconditionally) keeps an
    // undriven rgb_in during blanking from ever reaching the pins, and infers no latch.
    always_comb begin
        colour = 6'd0;
        if (!ctl_d.blank) begin
            colour = rgb_in;
        end
    end

    // rgb_in = {r1,r0,g1,g0,b1,b0}; pins = {hsync,b0,g0,r0,vsync,b1,g1,r1}.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_out <= VGA_IDLE;
        end else if (ena) begin
            vga_out <= {~ctl_d.hsync, colour[0], colour[2], colour[4],
                        ~ctl_d.vsync, colour[1], colour[3], colour[5]};
        end
    end

endmodule

// File: tb/tb_vga_timing_out.sv
// Self-checking bench for vga_timing_out: full-size timing instance plus a shrunken
// zero-latency instance for frame-level and reset corner cases, both against a position model.
module tb_vga_timing_out;

    typedef struct packed {
        int ha; int hfp; int hsw; int hbp;
        int va; int vfp; int vsw; int vbp;
        int lat;
    } tcfg_t;

    localparam tcfg_t CFG_A = '{ha: 640, hfp: 16, hsw: 96, hbp: 48,
                                va: 480, vfp: 10, vsw: 2, vbp: 33, lat: 2};
    localparam tcfg_t CFG_B = '{ha: 16, hfp: 2, hsw: 4, hbp: 3,
                                va: 6, vfp: 1, vsw: 2, vbp: 2, lat: 0};

    localparam int HIST = 8192;

    logic       clk = 1'b0;
    logic       rst_a, ena_a, rst_b, ena_b;
    logic [5:0] rgb_a, rgb_b;
    logic [9:0] px_a, py_a, px_b, py_b;
    logic       pv_a, ls_a, fs_a, pv_b, ls_b, fs_b;
    logic [7:0] vo_a, vo_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: enabled clock edges since reset, and the rgb sampled at each one.
    int         k_a = 0;
    int         k_b = 0;
    logic [5:0] hist_a [HIST];
    logic [5:0] hist_b [HIST];

    always #20 clk = ~clk;

    vga_timing_out #(
        .H_ACTIVE(CFG_A.ha), .H_FP(CFG_A.hfp), .H_SYNC(CFG_A.hsw), .H_BP(CFG_A.hbp),
        .V_ACTIVE(CFG_A.va), .V_FP(CFG_A.vfp), .V_SYNC(CFG_A.vsw), .V_BP(CFG_A.vbp),
        .RENDER_LAT(CFG_A.lat)
    ) dut_a (
        .clk(clk), .rst(rst_a), .ena(ena_a),
        .pix_x(px_a), .pix_y(py_a), .pix_valid(pv_a),
        .line_start(ls_a), .frame_start(fs_a),
        .rgb_in(rgb_a), .vga_out(vo_a)
    );

    vga_timing_out #(
        .H_ACTIVE(CFG_B.ha), .H_FP(CFG_B.hfp), .H_SYNC(CFG_B.hsw), .H_BP(CFG_B.hbp),
        .V_ACTIVE(CFG_B.va), .V_FP(CFG_B.vfp), .V_SYNC(CFG_B.vsw), .V_BP(CFG_B.vbp),
        .RENDER_LAT(CFG_B.lat)
    ) dut_b (
        .clk(clk), .rst(rst_b), .ena(ena_b),
        .pix_x(px_b), .pix_y(py_b), .pix_valid(pv_b),
        .line_start(ls_b), .frame_start(fs_b),
        .rgb_in(rgb_b), .vga_out(vo_b)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int htot(tcfg_t c);
        return c.ha + c.hfp + c.hsw + c.hbp;
    endfunction

    function automatic int vtot(tcfg_t c);
        return c.va + c.vfp + c.vsw + c.vbp;
    endfunction

    // Is the j-th issued coordinate (counting from reset) outside the visible area?
    function automatic logic coord_blank(tcfg_t c, int j);
        int pos;
        if (j < 0) return 1'b1;
        pos = j % (htot(c) * vtot(c));
        return !((pos % htot(c)) < c.ha && (pos / htot(c)) < c.va);
    endfunction

    // Pin word after k enabled edges; rgb is the colour sampled on edge k-1.
    function automatic logic [7:0] exp_vga(tcfg_t c, int k, logic [5:0] rgb);
        int j, pos, h, v;
        logic hs, vs;
        logic [5:0] col;
        if (k < c.lat + 1) return 8'h88;
        j   = k - 1 - c.lat;
        pos = j % (htot(c) * vtot(c));
        h   = pos % htot(c);
        v   = pos / htot(c);
        hs  = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hsw);
        vs  = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vsw);
        col = coord_blank(c, j) ? 6'd0 : rgb;
        return {~hs, col[0], col[2], col[4], ~vs, col[1], col[3], col[5]};
    endfunction

    task automatic model_check(string tag, tcfg_t c, int k, logic en, logic [5:0] rgbp,
                               logic [9:0] px, logic [9:0] py, logic pv, logic ls,
                               logic fs, logic [7:0] vo);
        int pos, h, v;
        pos = k % (htot(c) * vtot(c));
        h   = pos % htot(c);
        v   = pos / htot(c);
        check({tag, "_pix_x"}, px, h);
        check({tag, "_pix_y"}, py, v);
        check({tag, "_pix_valid"}, pv, (h < c.ha) && (v < c.va));
        check({tag, "_line_start"}, ls, en && (h == 0));
        check({tag, "_frame_start"}, fs, en && (pos == 0));
        check({tag, "_vga_out"}, vo, exp_vga(c, k, rgbp));
    endtask

    task automatic sample();
        @(negedge clk);
        model_check("a", CFG_A, k_a, ena_a, (k_a > 0) ? hist_a[k_a-1] : 6'd0,
                    px_a, py_a, pv_a, ls_a, fs_a, vo_a);
        model_check("b", CFG_B, k_b, ena_b, (k_b > 0) ? hist_b[k_b-1] : 6'd0,
                    px_b, py_b, pv_b, ls_b, fs_b, vo_b);
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst_a && ena_a && k_a < HIST) begin
            hist_a[k_a] = rgb_a;
            k_a++;
        end
        if (!rst_b && ena_b && k_b < HIST) begin
            hist_b[k_b] = rgb_b;
            k_b++;
        end
        #1;
    endtask

    typedef struct {
        int         cyc;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
        logic [7:0] vo;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int         vi, first_low, n_low, found;
        logic [7:0] vo_hold;

        vecs.push_back('{0,   10'd0,   10'd0, 1'b1, 1'b1, 8'h88});
        vecs.push_back('{2,   10'd2,   10'd0, 1'b0, 1'b0, 8'h88});
        vecs.push_back('{3,   10'd3,   10'd0, 1'b0, 1'b0, 8'hFF});
        vecs.push_back('{642, 10'd642, 10'd0, 1'b0, 1'b0, 8'hFF});
        vecs.push_back('{643, 10'd643, 10'd0, 1'b0, 1'b0, 8'h88});
        vecs.push_back('{658, 10'd658, 10'd0, 1'b0, 1'b0, 8'h88});
        vecs.push_back('{659, 10'd659, 10'd0, 1'b0, 1'b0, 8'h08});
        vecs.push_back('{754, 10'd754, 10'd0, 1'b0, 1'b0, 8'h08});
        vecs.push_back('{755, 10'd755, 10'd0, 1'b0, 1'b0, 8'h88});
        vecs.push_back('{799, 10'd799, 10'd0, 1'b0, 1'b0, 8'h88});
        vecs.push_back('{800, 10'd0,   10'd1, 1'b1, 1'b0, 8'h88});
        vecs.push_back('{803, 10'd3,   10'd1, 1'b0, 1'b0, 8'hFF});

        rst_a = 1'b1; ena_a = 1'b1; rgb_a = 6'h3F;
        rst_b = 1'b1; ena_b = 1'b1; rgb_b = 6'h00;

        // Reset held: idle pin word on both instances.
        for (int i = 0; i < 3; i++) begin
            sample();
            check("rst_vga_a", vo_a, 8'h88);
            check("rst_vga_b", vo_b, 8'h88);
            advance();
        end
        rst_a = 1'b0;

        // First line and a bit of the second with constant white.
        vi = 0; first_low = -1; n_low = 0;
        for (int c = 0; c <= 810; c++) begin
            sample();
            if (vi < vecs.size() && vecs[vi].cyc == c) begin
                check($sformatf("vec%0d_x", c),  px_a, vecs[vi].x);
                check($sformatf("vec%0d_y", c),  py_a, vecs[vi].y);
                check($sformatf("vec%0d_ls", c), ls_a, vecs[vi].ls);
                check($sformatf("vec%0d_fs", c), fs_a, vecs[vi].fs);
                check($sformatf("vec%0d_vo", c), vo_a, vecs[vi].vo);
                vi++;
            end
            if (!vo_a[7]) begin
                n_low++;
                if (first_low < 0) first_low = c;
            end
            advance();
        end
        check("hsync_low_count", n_low, 96);
        check("hsync_first_low", first_low, 659);

        // Freeze at h=300 for 10 cycles, then resume.
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            sample();
            if (px_a == 10'd300) found = 1;
            else advance();
        end
        check("reach_h300", found, 1);
        vo_hold = vo_a;
        ena_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            advance();
            sample();
            check("freeze_x", px_a, 10'd300);
            check("freeze_vo", vo_a, vo_hold);
            check("freeze_ls", ls_a, 1'b0);
        end
        ena_a = 1'b1;
        advance();
        sample();
        check("resume_x", px_a, 10'd301);
        advance();

        // Random enable and colour, undriven colour whenever it must be ignored.
        for (int i = 0; i < 2500; i++) begin
            sample();
            ena_a = ($urandom_range(0, 3) != 0);
            rgb_a = coord_blank(CFG_A, k_a - CFG_A.lat) ? 6'bx : 6'($urandom);
            advance();
        end
        ena_a = 1'b0;

        // Small instance: one full frame plus a frame boundary.
        rst_b = 1'b0;
        rgb_b = 6'h2A;
        first_low = -1; n_low = 0;
        for (int c = 0; c <= 300; c++) begin
            sample();
            if (!vo_b[3]) begin
                n_low++;
                if (first_low < 0) first_low = c;
            end
            if (c == 275) begin
                check("frame2_fs", fs_b, 1'b1);
                check("frame2_y", py_b, 10'd0);
            end
            advance();
        end
        check("vsync_low_count", n_low, CFG_B.vsw * htot(CFG_B));
        check("vsync_first_low", first_low,
              (CFG_B.va + CFG_B.vfp) * htot(CFG_B) + CFG_B.lat + 1);

        // Async reset in the last vsync line, inside the hsync pulse.
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            sample();
            if (px_b == 10'd20 && py_b == 10'd8) found = 1;
            else advance();
        end
        check("reach_h20_v8", found, 1);
        check("pre_rst_vo", vo_b, 8'h00);
        rst_b = 1'b1;
        k_b   = 0;
        #1;
        check("async_rst_vo", vo_b, 8'h88);
        check("async_rst_x", px_b, 10'd0);
        check("async_rst_y", py_b, 10'd0);
        advance();
        advance();
        rst_b = 1'b0;
        sample();
        check("post_rst_fs", fs_b, 1'b1);
        check("post_rst_x", px_b, 10'd0);
        advance();

        for (int i = 0; i < 2000; i++) begin
            sample();
            ena_b = ($urandom_range(0, 3) != 0);
            rgb_b = coord_blank(CFG_B, k_b - CFG_B.lat) ? 6'bx : 6'($urandom);
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
